// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//
// Synthesizable 4x4 keypad model. It responds to a row scanner the way a
// physical keypad would. A command "press key K for H cycles" closes one
// contact. While that contact is closed, the key's column line follows the
// key's row line.
//
// Optional feature macro: KEYPAD_EMU_BOUNCE_EN
//   defined   : PRESS and RELEASE each run a contact-bounce phase of
//               (BOUNCE_TOGGLES+1)*BOUNCE_PERIOD cycles.
//   undefined : PRESS and RELEASE are single clean cycles, and no bounce
//               logic is built.
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_cmd_valid  command present
//   o_cmd_ready  command can be accepted (high only in IDLE)
//   i_cmd_key    key code: row = [3:2], col = [1:0]
//   i_cmd_hold   cycles the contact stays solidly closed (0 counts as 1)
//   i_row        row select from the scanner, active-high
//   o_col        column return, active-high
//   o_busy       high in any state other than IDLE
//   o_done       one-cycle pulse during the last GAP cycle
// ---------------------------------------------------------------------------
module keypad_emulator #(
    parameter int unsigned HOLD_W         = 16,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned BOUNCE_PERIOD  = 4,
    parameter int unsigned BOUNCE_TOGGLES = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd_key,
    input  logic [HOLD_W-1:0] i_cmd_hold,
    input  logic [3:0]        i_row,
    output logic [3:0]        o_col,
    output logic              o_busy,
    output logic              o_done
);

    // Reject parameter sets the timing scheme cannot represent.
    if (GAP_CYCLES < 1 || BOUNCE_PERIOD < 1 || (BOUNCE_TOGGLES % 2) == 0) begin : g_bad_params
        $error("keypad_emulator: GAP_CYCLES and BOUNCE_PERIOD must be >= 1, BOUNCE_TOGGLES odd");
    end

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int unsigned PCNT_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int unsigned SEG_W  = $clog2(BOUNCE_TOGGLES + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(BOUNCE_TOGGLES);
    localparam logic [SEG_W-1:0]  SEG_TOG   = SEG_W'(BOUNCE_TOGGLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD,
        ST_RELEASE,
        ST_GAP
    } state_t;

    state_t            r_state;
    logic              r_contact;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_key;
    logic [HOLD_W-1:0] r_hold_len;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [PCNT_W-1:0] r_pcnt;
    logic [SEG_W-1:0]  r_seg;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_contact  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_key      <= '0;
            r_hold_len <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_pcnt     <= '0;
            r_seg      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_contact <= 1'b0;
                    r_done    <= 1'b0;
                    if (i_cmd_valid) begin
                        r_state    <= ST_PRESS;
                        r_busy     <= 1'b1;
                        r_key      <= i_cmd_key;
                        r_hold_len <= (i_cmd_hold == '0) ? HOLD_W'(1) : i_cmd_hold;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        // The first bounce toggle is the initial closure itself.
                        r_contact  <= 1'b1;
                        r_pcnt     <= '0;
                        r_seg      <= '0;
`endif
                    end
                end

                ST_PRESS: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    // Segments 0..T last one period each. A toggle happens at the
                    // start of segments 1..T-1, so the last two segments stay closed.
                    if (r_pcnt == PCNT_LAST) begin
                        r_pcnt <= '0;
                        if (r_seg == SEG_LAST) begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= '0;
                        end else begin
                            r_seg <= r_seg + 1'b1;
                            if (r_seg < SEG_TOG) begin
                                r_contact <= ~r_contact;
                            end
                        end
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
`else
                    r_contact  <= 1'b1;
                    r_state    <= ST_HOLD;
                    r_hold_cnt <= '0;
`endif
                end

                ST_HOLD: begin
                    if (r_hold_cnt == r_hold_len - 1'b1) begin
                        r_state   <= ST_RELEASE;
                        r_contact <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        r_pcnt    <= '0;
                        r_seg     <= '0;
`endif
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    // Mirror of PRESS. Entry opened the contact, and the last two
                    // segments stay open.
                    if (r_pcnt == PCNT_LAST) begin
                        r_pcnt <= '0;
                        if (r_seg == SEG_LAST) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                            r_done    <= (GAP_LAST == '0);
                        end else begin
                            r_seg <= r_seg + 1'b1;
                            if (r_seg < SEG_TOG) begin
                                r_contact <= ~r_contact;
                            end
                        end
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
`else
                    r_state   <= ST_GAP;
                    r_gap_cnt <= '0;
                    r_done    <= (GAP_LAST == '0);
`endif
                end

                ST_GAP: begin
                    r_contact <= 1'b0;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                        // Register done so that it is high during the final GAP cycle.
                        r_done    <= ((r_gap_cnt + 1'b1) == GAP_LAST);
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_contact <= 1'b0;
                end
            endcase
        end
    end

    // The column follows the scanned row live, but only for the latched key.
    always_comb begin
        o_col = '0;
        if (r_contact && i_row[r_key[3:2]]) begin
            o_col[r_key[1:0]] = 1'b1;
        end
    end

    assign o_cmd_ready = ~r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//
// Inputs are driven on the falling edge and outputs are checked 1 ns later.
// The reference model keeps only "cycles since accept" for the command in
// flight. It derives contact, busy, ready and done from the keypad's timing
// rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int unsigned HW  = 8;
    localparam int unsigned GAP = 5;
    localparam int unsigned BP  = 4;
    localparam int unsigned BT  = 5;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif
    localparam int unsigned PH = BOUNCE ? (BT + 1) * BP : 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_key;
    logic [HW-1:0] cmd_hold;
    logic [3:0]    row;
    logic [3:0]    col;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_W        (HW),
        .GAP_CYCLES    (GAP),
        .BOUNCE_PERIOD (BP),
        .BOUNCE_TOGGLES(BT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_key  (cmd_key),
        .i_cmd_hold (cmd_hold),
        .i_row      (row),
        .o_col      (col),
        .o_busy     (busy),
        .o_done     (done)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    bit          m_known  = 1'b0;
    bit          m_active = 1'b0;
    int unsigned m_k      = 0;
    int unsigned m_len    = 1;
    logic [3:0]  m_key    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned busy_len(input int unsigned h);
        return BOUNCE ? (2 * PH + h + GAP) : (h + GAP + 2);
    endfunction

    // Contact level k cycles after the accepting edge, for hold length h.
    function automatic bit exp_contact(input int unsigned k, input int unsigned h);
        int unsigned s;
        if (BOUNCE) begin
            if (k < PH) begin
                s = k / BP;
                return (s >= BT - 1) ? 1'b1 : ((s % 2) == 0);
            end
            if (k < PH + h) return 1'b1;
            if (k < 2 * PH + h) begin
                s = (k - PH - h) / BP;
                return (s >= BT - 1) ? 1'b0 : ((s % 2) == 1);
            end
            return 1'b0;
        end
        return (k >= 1) && (k <= h);
    endfunction

    task automatic step(input bit rst, input bit v, input logic [3:0] key,
                        input logic [HW-1:0] hold, input logic [3:0] r);
        logic [3:0] e_col;
        bit         e_ct;
        @(negedge clk);
        reset     = rst;
        cmd_valid = v;
        cmd_key   = key;
        cmd_hold  = hold;
        row       = r;
        #1;
        if (m_known) begin
            e_ct  = m_active && exp_contact(m_k, m_len);
            e_col = '0;
            if (e_ct && r[m_key[3:2]]) e_col[m_key[1:0]] = 1'b1;
            check("col", 32'(col), 32'(e_col));
            check("cmd_ready", 32'(cmd_ready), 32'(!m_active));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_active && (m_k == busy_len(m_len) - 1)));
        end
        @(posedge clk);
        if (rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
        end else if (m_known) begin
            if (!m_active) begin
                if (v) begin
                    m_active = 1'b1;
                    m_k      = 0;
                    m_key    = key;
                    m_len    = (hold == '0) ? 1 : int'(hold);
                end
            end else begin
                m_k++;
                if (m_k == busy_len(m_len)) m_active = 1'b0;
            end
        end
    endtask

    task automatic run_idle(input logic [3:0] r, input int unsigned limit);
        int unsigned n = 0;
        while (m_active && n < limit) begin
            step(1'b0, 1'b0, 4'h0, '0, r);
            n++;
        end
        check("idle_within_bound", 32'(m_active), 32'(0));
        step(1'b0, 1'b0, 4'h0, '0, r);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = '0;
        cmd_hold  = '0;
        row       = '0;

        // Reset held for two cycles
        step(1'b1, 1'b0, 4'h0, '0, 4'b0000);
        step(1'b1, 1'b0, 4'h0, '0, 4'b0000);
        step(1'b0, 1'b0, 4'h0, '0, 4'b0000);

        // Key 6 with a hold of 20 cycles on a steady matching row
        step(1'b0, 1'b1, 4'h6, HW'(20), 4'b0010);
        run_idle(4'b0010, 500);

        // Key F while the row scan rotates every 4 cycles
        step(1'b0, 1'b1, 4'hF, HW'(40), 4'b0001);
        for (int i = 0; i < 200 && m_active; i++) begin
            logic [3:0] rr;
            rr = 4'b0001 << ((i / 4) % 4);
            step(1'b0, 1'b0, 4'h0, '0, rr);
        end
        run_idle(4'b1000, 500);

        // Second command arriving while busy must be ignored
        step(1'b0, 1'b1, 4'h4, HW'(10), 4'b0011);
        for (int i = 0; i < 200 && m_active; i++) begin
            step(1'b0, 1'b1, 4'h1, HW'(10), 4'b0011);
        end
        step(1'b0, 1'b0, 4'h0, '0, 4'b0011);
        run_idle(4'b0011, 500);

        // Reset during the hold of key 0
        step(1'b0, 1'b1, 4'h0, HW'(20), 4'b0001);
        for (int i = 0; i < 5 + int'(PH); i++) step(1'b0, 1'b0, 4'h0, '0, 4'b0001);
        step(1'b1, 1'b0, 4'h0, '0, 4'b0001);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'h0, '0, 4'b0001);

        // Hold of 0 gives one solid cycle, and the maximum hold runs its full length
        step(1'b0, 1'b1, 4'h9, HW'(0), 4'b0100);
        run_idle(4'b0100, 500);
        step(1'b0, 1'b1, 4'hA, '1, 4'b0100);
        run_idle(4'b0100, 1000);

        // Back-to-back commands with cmd_valid held high
        for (int i = 0; i < 120; i++) begin
            logic [3:0] kk;
            kk = 4'(i / 40 + 3);
            step(1'b0, 1'b1, kk, HW'(3), 4'b1111);
        end
        run_idle(4'b1111, 500);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic [3:0]    rr;
            logic [HW-1:0] hh;
            bit            vv;
            bit            rs;
            rr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       hh = '0;
                1:       hh = HW'(1);
                2:       hh = HW'($urandom_range(2, 6));
                default: hh = HW'($urandom_range(7, 30));
            endcase
            vv = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 399) == 0);
            step(rs, vv, 4'($urandom), hh, rr);
        end
        run_idle(4'b0000, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
